sdfm_result_arb: RTL and testbench

Collects filtered results from NCH sigma-delta channels and forwards them one at a time on a single valid/ready output port. Each channel has a holding register and a pending flag. A round-robin arbiter grants pending channels in turn. Lost results are reported through sticky per-channel overrun flags. The block sits between the per-channel filter outputs (32-bit data plus an update strobe) and the register/bus interface or a result FIFO.

---
 rtl/sdfm_result_arb.sv | 135 +++++++++++++
 tb/tb_sdfm_result_arb.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdfm_result_arb.sv
// Sigma-delta result arbiter: per-channel holding registers, round-robin grant
// onto one valid/ready port, sticky overrun flags. Optional SDFM_ARB_PRIO0_EN.
//
// Ports:
//   SYSCLK, SYSRSTn        clock, async active-low reset
//   ch_data/ch_update/ch_en per-channel filter data, update strobe, enable
//   out_data/out_ch/out_valid/out_ready  granted result handshake
//   pending/ovf_flag/ovf_clr  unread-result flags, sticky overrun, W1C clear
module sdfm_result_arb #(
  parameter int NCH = 4,
  parameter int DW  = 32,
  parameter int CW  = 2
) (
  input  logic              SYSCLK,
  input  logic              SYSRSTn,
  input  logic [NCH*DW-1:0] ch_data,
  input  logic [NCH-1:0]    ch_update,
  input  logic [NCH-1:0]    ch_en,
  output logic [DW-1:0]     out_data,
  output logic [CW-1:0]     out_ch,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NCH-1:0]    pending,
  output logic [NCH-1:0]    ovf_flag,
  input  logic [NCH-1:0]    ovf_clr
);

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t         state, state_nxt;
  logic [NCH-1:0] upd_d;
  logic [NCH-1:0] cap;
  logic [NCH-1:0] req;
  logic [NCH-1:0] rr_req;
  logic [NCH-1:0] gnt;
  logic [DW-1:0]  hold [NCH];
  logic [CW-1:0]  last_grant;
  logic [CW-1:0]  sel;
  logic [CW-1:0]  idx;
  logic           found;
  logic           upd_last;
  logic           go;

  assign cap = ch_update & ~upd_d & ch_en;
  // a disabled channel is never granted even while its flag drains
  assign req = pending & ch_en;

  always_comb begin
    sel      = '0;
    found    = 1'b0;
    upd_last = 1'b0;
    idx      = last_grant;
`ifdef SDFM_ARB_PRIO0_EN
    rr_req   = req & {{(NCH-1){1'b1}}, 1'b0};
`else
    rr_req   = req;
`endif
    for (int i = 0; i < NCH; i++) begin
      idx = (idx == CW'(NCH-1)) ? '0 : idx + 1'b1;
      if (!found && rr_req[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
    upd_last = found;
`ifdef SDFM_ARB_PRIO0_EN
    // channel 0 overrides and leaves the round-robin pointer alone
    if (req[0]) begin
      found    = 1'b1;
      sel      = '0;
      upd_last = 1'b0;
    end
`endif
  end

  assign go = (state == IDLE) && found;

  always_comb begin
    gnt = '0;
    for (int k = 0; k < NCH; k++)
      gnt[k] = go && (sel == CW'(k));
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (found) state_nxt = PRESENT;
      PRESENT: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge SYSCLK or negedge SYSRSTn) begin
    if (!SYSRSTn) begin
      state      <= IDLE;
      upd_d      <= '0;
      out_data   <= '0;
      out_ch     <= '0;
      out_valid  <= 1'b0;
      pending    <= '0;
      ovf_flag   <= '0;
      last_grant <= CW'(NCH-1);
      for (int k = 0; k < NCH; k++)
        hold[k] <= '0;
    end else begin
      state <= state_nxt;
      upd_d <= ch_update;
      if (go) begin
        out_data  <= hold[sel];
        out_ch    <= sel;
        out_valid <= 1'b1;
        if (upd_last)
          last_grant <= sel;
      end else if (state == PRESENT && out_ready) begin
        out_valid <= 1'b0;
      end
      for (int k = 0; k < NCH; k++) begin
        if (cap[k])
          hold[k] <= ch_data[k*DW +: DW];
        // a capture on the grant cycle refills the register: not an overrun
        if (!ch_en[k])
          pending[k] <= 1'b0;
        else if (cap[k])
          pending[k] <= 1'b1;
        else if (gnt[k])
          pending[k] <= 1'b0;
        if (cap[k] && pending[k] && !gnt[k])
          ovf_flag[k] <= 1'b1;
        else if (ovf_clr[k])
          ovf_flag[k] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sdfm_result_arb.sv
// Testbench for sdfm_result_arb: directed steps, scoreboard of expected
// transfers popped by a handshake monitor.
module tb_sdfm_result_arb;
  localparam int NCH = 4;
  localparam int DW  = 32;
  localparam int CW  = 2;

  logic              SYSCLK = 1'b0;
  logic              SYSRSTn;
  logic [NCH*DW-1:0] ch_data;
  logic [NCH-1:0]    ch_update;
  logic [NCH-1:0]    ch_en;
  logic [DW-1:0]     out_data;
  logic [CW-1:0]     out_ch;
  logic              out_valid;
  logic              out_ready;
  logic [NCH-1:0]    pending;
  logic [NCH-1:0]    ovf_flag;
  logic [NCH-1:0]    ovf_clr;

  sdfm_result_arb #(.NCH(NCH), .DW(DW), .CW(CW)) dut (
    .SYSCLK(SYSCLK), .SYSRSTn(SYSRSTn),
    .ch_data(ch_data), .ch_update(ch_update), .ch_en(ch_en),
    .out_data(out_data), .out_ch(out_ch),
    .out_valid(out_valid), .out_ready(out_ready),
    .pending(pending), .ovf_flag(ovf_flag), .ovf_clr(ovf_clr)
  );

  always #5 SYSCLK = ~SYSCLK;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  logic [CW+DW-1:0] sb [$];
  int               xcyc [$];
  logic             pv = 1'b0;
  logic             pr = 1'b0;
  logic [CW+DW-1:0] pd = '0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge SYSCLK) begin
    cyc++;
    if (SYSRSTn) begin
      if (pv && !pr) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", {out_ch, out_data}, pd);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $error("FAIL unexpected_xfer observed=%0h expected=none",
                 {out_ch, out_data});
        end else begin
          chk("xfer", {out_ch, out_data}, sb.pop_front());
          xcyc.push_back(cyc);
        end
      end
    end
    pv = out_valid & SYSRSTn;
    pr = out_ready;
    pd = {out_ch, out_data};
  end

  task automatic tick();
    @(posedge SYSCLK);
    #1;
  endtask

  task automatic setd(input int k, input logic [DW-1:0] v);
    ch_data[k*DW +: DW] = v;
  endtask

  task automatic pulse(input int k, input logic [DW-1:0] v);
    setd(k, v);
    ch_update[k] = 1'b1;
    tick();
    ch_update[k] = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    SYSRSTn   = 1'b0;
    ch_update = '0;
    ovf_clr   = '0;
    #1;
    chk("rst_valid", out_valid, 0);
    tick();
    chk("rst_data", out_data, 0);
    chk("rst_ch", out_ch, 0);
    chk("rst_pend", pending, 0);
    chk("rst_ovf", ovf_flag, 0);
    SYSRSTn = 1'b1;
    tick();
  endtask

  task automatic drain(input int maxc);
    int c = 0;
    while ((sb.size() != 0 || out_valid) && c < maxc) begin
      tick();
      c++;
    end
    chk("drain", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n0;
    SYSRSTn   = 1'b0;
    ch_data   = '0;
    ch_update = '0;
    ch_en     = '1;
    out_ready = 1'b1;
    ovf_clr   = '0;
    tick();
    do_reset();

    // single update on ch2: capture at edge n, valid after n+1
    setd(2, 32'h12345678);
    ch_update[2] = 1'b1;
    sb.push_back({2'd2, 32'h12345678});
    tick();
    chk("t1_pend", pending, 4'b0100);
    chk("t1_lat0", out_valid, 0);
    ch_update[2] = 1'b0;
    tick();
    chk("t1_lat1", out_valid, 1);
    chk("t1_data", out_data, 32'h12345678);
    chk("t1_ch", out_ch, 2);
    tick();
    chk("t1_pend0", pending, 0);
    chk("t1_ovf", ovf_flag, 0);
    chk("t1_done", out_valid, 0);

    // all four at once: ch0..ch3, 2 cycles apart
    do_reset();
    n0 = xcyc.size();
    for (int k = 0; k < NCH; k++) begin
      setd(k, 32'hA0 + k);
      sb.push_back({CW'(k), 32'hA0 + k});
    end
    ch_update = '1;
    tick();
    ch_update = '0;
    drain(30);
    chk("t2_count", xcyc.size() - n0, 4);
    if (xcyc.size() >= n0 + 4)
      for (int i = 1; i < 4; i++)
        chk("t2_spacing", xcyc[n0+i] - xcyc[n0+i-1], 2);

    // overrun on ch1 under back-pressure
    do_reset();
    out_ready = 1'b0;
    sb.push_back({2'd1, 32'h11});
    sb.push_back({2'd1, 32'h33});
    pulse(1, 32'h11);
    chk("t3_valid", out_valid, 1);
    chk("t3_d11", out_data, 32'h11);
    pulse(1, 32'h22);
    chk("t3_ovf0", ovf_flag, 0);
    chk("t3_pend", pending, 4'b0010);
    pulse(1, 32'h33);
    chk("t3_ovf1", ovf_flag, 4'b0010);
    chk("t3_hold11", out_data, 32'h11);
    out_ready = 1'b1;
    drain(20);
    chk("t3_sticky", ovf_flag, 4'b0010);
    ovf_clr = 4'b0010;
    tick();
    ovf_clr = '0;
    chk("t3_clr", ovf_flag, 0);

    // level strobe on ch3 captures once
    n0 = xcyc.size();
    setd(3, 32'h55);
    sb.push_back({2'd3, 32'h55});
    ch_update[3] = 1'b1;
    repeat (10) tick();
    ch_update[3] = 1'b0;
    drain(20);
    repeat (4) tick();
    chk("t4_once", xcyc.size() - n0, 1);

    // disabled channel captures nothing
    n0 = xcyc.size();
    ch_en[3] = 1'b0;
    ch_update[3] = 1'b1;
    repeat (10) tick();
    chk("t5_pend", pending[3], 0);
    ch_update[3] = 1'b0;
    ch_en[3] = 1'b1;
    repeat (4) tick();
    chk("t5_pend2", pending[3], 0);
    chk("t5_none", xcyc.size() - n0, 0);

    // capture on ch0 in its grant cycle
    do_reset();
    out_ready = 1'b0;
    sb.push_back({2'd1, 32'hB1});
    sb.push_back({2'd0, 32'h01});
    sb.push_back({2'd0, 32'h02});
    pulse(1, 32'hB1);
    pulse(0, 32'h01);
    out_ready = 1'b1;
    tick();
    setd(0, 32'h02);
    ch_update[0] = 1'b1;
    tick();
    chk("t6_old", out_data, 32'h01);
    chk("t6_ch", out_ch, 0);
    chk("t6_pend", pending[0], 1);
    chk("t6_ovf", ovf_flag[0], 0);
    ch_update[0] = 1'b0;
    drain(20);
    chk("t6_ovf2", ovf_flag, 0);

    // ch0 arrives while ch2 waits: order depends on the priority option
    do_reset();
    out_ready = 1'b0;
    setd(1, 32'hD1);
    setd(2, 32'hD2);
    sb.push_back({2'd1, 32'hD1});
`ifdef SDFM_ARB_PRIO0_EN
    sb.push_back({2'd0, 32'hC0});
    sb.push_back({2'd2, 32'hD2});
`else
    sb.push_back({2'd2, 32'hD2});
    sb.push_back({2'd0, 32'hC0});
`endif
    ch_update = 4'b0110;
    tick();
    ch_update = '0;
    tick();
    setd(0, 32'hC0);
    ch_update[0] = 1'b1;
    tick();
    ch_update[0] = 1'b0;
    out_ready = 1'b1;
    drain(20);

    // reset mid-transfer discards the result
    out_ready = 1'b0;
    pulse(2, 32'hEE);
    chk("t8_valid", out_valid, 1);
    do_reset();
    chk("t8_gone", out_valid, 0);
    out_ready = 1'b1;
    repeat (4) tick();
    chk("t8_sb", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
